// File: rtl/cello_tt_pkg.sv
// cello_tt_pkg: shared types and helpers for the Cello truth-table readers.
//   state_t      - reader sequencing states
//   tt_width(n)  - truth-table width for an n-input netlist (2**n)
//   row_to_bit() - truth-table bit that holds a given row (row 0 -> MSB)
//   TT_0xD4E4    - reference code of the m0xD4E4 netlist
package cello_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] TT_0xD4E4 = 16'hD4E4;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

  // Cello hex convention: input combination 0 is the leftmost hex digit's MSB.
  function automatic int row_to_bit(input int n, input int row);
    return (1 << n) - 1 - row;
  endfunction

endpackage

// File: rtl/cello_tt_reader_if.sv
// cello_tt_reader_if: handshake and netlist-stimulus bundle of one reader.
//   start   - request to begin a sweep        (harness -> reader)
//   dut_out - netlist output                  (harness -> reader)
//   busy    - sweep in progress               (reader -> harness)
//   done    - one-cycle completion pulse      (reader -> harness)
//   drv_in  - netlist input stimulus          (reader -> harness)
//   tt      - captured truth table            (reader -> harness)
//   match   - tt equals the expected code     (reader -> harness)
//   unstable- sticky row-instability flag, only with CELLO_TT_STABLE_CHECK_EN
// N_IN must equal the N_IN of the reader attached to the slave modport.
interface cello_tt_reader_if #(
  parameter int N_IN = 4
);
  logic                  start;
  logic                  dut_out;
  logic                  busy;
  logic                  done;
  logic [N_IN-1:0]       drv_in;
  logic [(1<<N_IN)-1:0]  tt;
  logic                  match;
`ifdef CELLO_TT_STABLE_CHECK_EN
  logic                  unstable;
`endif

  // Harness side: requests sweeps and returns the netlist response.
  modport master (
    output start, dut_out,
`ifdef CELLO_TT_STABLE_CHECK_EN
    input  unstable,
`endif
    input  busy, done, drv_in, tt, match
  );

  // Reader side.
  modport slave (
    input  start, dut_out,
`ifdef CELLO_TT_STABLE_CHECK_EN
    output unstable,
`endif
    output busy, done, drv_in, tt, match
  );
endinterface

// File: rtl/cello_tt_settle_cnt.sv
// cello_tt_settle_cnt: loadable down-counter with zero flag.
//   clk, rst_n  - clock, asynchronous active-low reset (count resets to 0)
//   i_load      - load i_load_val (has priority over decrement)
//   i_load_val  - value to load
//   i_dec       - decrement; saturates at zero
//   o_zero      - count is zero
module cello_tt_settle_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/cello_tt_reader.sv
// cello_tt_reader: sweeps all 2**N_IN input combinations of a Cello netlist,
// holds each for SETTLE_CYCLES cycles, samples the netlist output on the last
// cycle of the row and assembles the hex truth table (row 0 in the MSB).
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - cello_tt_reader_if.slave (start/busy/done/drv_in/dut_out/tt/match)
// Optional: define CELLO_TT_STABLE_CHECK_EN to add the sticky bus.unstable
// flag, set when dut_out changes within a row; a set flag forces match low.
module cello_tt_reader
  import cello_tt_pkg::*;
#(
  parameter int                           N_IN          = 4,
  parameter int                           SETTLE_CYCLES = 2,
  parameter logic [tt_width(N_IN)-1:0]    EXPECTED      = TT_0xD4E4
) (
  input  logic              clk,
  input  logic              rst_n,
  cello_tt_reader_if.slave  bus
);
  localparam int              ROWS       = tt_width(N_IN);
  localparam logic [N_IN-1:0] LAST_ROW   = N_IN'(ROWS - 1);
  localparam logic [7:0]      CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t          r_state;
  logic [N_IN-1:0] r_row;
  logic [N_IN-1:0] r_drv;
  logic [ROWS-1:0] r_tt;
  logic            r_match;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic            w_run;
  logic            w_last;
  logic            w_cnt_zero;
  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic [N_IN-1:0] w_bit_idx;
  logic [ROWS-1:0] w_tt_sampled;
  logic            w_unstable_next;

  assign w_run      = (r_state == ST_RUN);
  assign w_accept   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_row == LAST_ROW);
  assign w_cnt_load = w_accept || (w_run && w_cnt_zero && !w_last);
  assign w_cnt_dec  = w_run && !w_cnt_zero;
  assign w_bit_idx  = N_IN'(row_to_bit(N_IN, int'(r_row)));

  always_comb begin
    w_tt_sampled            = r_tt;
    w_tt_sampled[w_bit_idx] = bus.dut_out;
  end

  cello_tt_settle_cnt #(.W(8)) u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_RELOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

`ifdef CELLO_TT_STABLE_CHECK_EN
  // r_ref holds dut_out from the first cycle of the current row; every later
  // cycle of that row is compared against it.
  logic r_first;
  logic r_ref;
  logic r_unstable;

  assign w_unstable_next = r_unstable || (w_run && !r_first && (bus.dut_out != r_ref));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first    <= 1'b0;
      r_ref      <= 1'b0;
      r_unstable <= 1'b0;
    end else if (w_accept) begin
      r_first    <= 1'b1;
      r_unstable <= 1'b0;
    end else if (w_run) begin
      r_unstable <= w_unstable_next;
      if (r_first) r_ref <= bus.dut_out;
      r_first    <= w_cnt_zero && !w_last;
    end
  end

  assign bus.unstable = r_unstable;
`else
  assign w_unstable_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_drv   <= '0;
      r_tt    <= '0;
      r_match <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_row   <= '0;
            r_drv   <= '0;
            r_tt    <= '0;
            r_match <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_cnt_zero) begin
            r_tt <= w_tt_sampled;
            if (!w_last) begin
              r_row <= r_row + 1'b1;
              r_drv <= r_row + 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_drv   <= '0;
              r_match <= (w_tt_sampled == EXPECTED) && !w_unstable_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.drv_in = r_drv;
  assign bus.tt     = r_tt;
  assign bus.match  = r_match;
endmodule

// File: tb/tb_cello_tt_reader.sv
// tb_cello_tt_reader: drives two readers (SETTLE_CYCLES=2 and 1) with a
// behavioural netlist (per-row output table) and checks sweeps, timing,
// reset, ignored starts and (with CELLO_TT_STABLE_CHECK_EN) instability.
module tb_cello_tt_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // r_rows[i] is the netlist output for input combination i.
  logic [15:0] r_rows;
  logic        r_glitch = 1'b0;
  logic        r_start0 = 1'b0;
  logic        r_start1 = 1'b0;
  logic        r_sel = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  cello_tt_reader_if #(.N_IN(4)) b0();
  cello_tt_reader_if #(.N_IN(4)) b1();

  assign b0.start   = r_start0;
  assign b1.start   = r_start1;
  assign b0.dut_out = r_rows[b0.drv_in] ^ r_glitch;
  assign b1.dut_out = r_rows[b1.drv_in];

  cello_tt_reader #(.N_IN(4), .SETTLE_CYCLES(2), .EXPECTED(16'hD4E4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  cello_tt_reader #(.N_IN(4), .SETTLE_CYCLES(1), .EXPECTED(16'hD4E4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  logic        m_busy, m_done, m_match;
  logic [3:0]  m_drv;
  logic [15:0] m_tt;
  always_comb begin
    m_busy  = r_sel ? b1.busy   : b0.busy;
    m_done  = r_sel ? b1.done   : b0.done;
    m_match = r_sel ? b1.match  : b0.match;
    m_drv   = r_sel ? b1.drv_in : b0.drv_in;
    m_tt    = r_sel ? b1.tt     : b0.tt;
  end

  task automatic set_func(input logic [15:0] word);
    for (int i = 0; i < 16; i++) r_rows[i] = word[15-i];
  endtask

  // Reference: row 0 is the leftmost bit of the hex word.
  function automatic logic [15:0] model_tt(input logic [15:0] rows);
    logic [15:0] acc = '0;
    for (int row = 0; row < 16; row++) acc = {acc[14:0], rows[row]};
    return acc;
  endfunction

  task automatic set_start(input logic v);
    if (r_sel) r_start1 = v; else r_start0 = v;
  endtask

  // Starts a sweep on the selected reader; k counts edges after the accept edge.
  task automatic run_sweep(input int s1, input int s2, input int glitch_k,
                           output int done_k, output int drv_err,
                           output int pulses, output int late_busy);
    int settle = r_sel ? 1 : 2;
    int k = 0;
    done_k = -1; drv_err = 0; pulses = 0; late_busy = 0;
    @(negedge clk); set_start(1'b1);
    @(posedge clk);
    @(negedge clk); set_start(1'b0);
    while (k < 200 && done_k < 0) begin
      if (m_done) begin
        done_k = k; pulses++;
        if (m_drv !== 4'd0) drv_err++;
      end else if (m_drv !== 4'(k / settle) || m_busy !== 1'b1) begin
        drv_err++;
      end
      set_start((k == s1) || (k == s2));
      r_glitch = (k == glitch_k);
      @(negedge clk); k++;
    end
    set_start(1'b0); r_glitch = 1'b0;
    repeat (4) begin
      if (m_done) pulses++;
      if (m_busy) late_busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++; if (b0.busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", b0.busy); end
    n_tests++; if (b0.done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", b0.done); end
    n_tests++; if (b0.drv_in !== 4'd0) begin n_fail++; $display("FAIL reset_drv got %h want 0", b0.drv_in); end
    n_tests++; if (b0.tt !== 16'h0)   begin n_fail++; $display("FAIL reset_tt got %h want 0", b0.tt); end
    n_tests++; if (b0.match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %b want 0", b0.match); end
`ifdef CELLO_TT_STABLE_CHECK_EN
    n_tests++; if (b0.unstable !== 1'b0) begin n_fail++; $display("FAIL reset_unstable got %b want 0", b0.unstable); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (b0.busy !== 1'b0 || b0.done !== 1'b0) begin n_fail++; $display("FAIL idle_quiet got busy=%b done=%b want 0 0", b0.busy, b0.done); end
  endtask

  task automatic test_main;
    int dk, de, pl, lb;
    r_sel = 1'b0; set_func(16'hD4E4);
    run_sweep(-1, -1, -1, dk, de, pl, lb);
    n_tests++; if (dk !== 32)  begin n_fail++; $display("FAIL main_latency got %0d want 32", dk); end
    n_tests++; if (de !== 0)   begin n_fail++; $display("FAIL main_drv_steps got %0d bad cycles want 0", de); end
    n_tests++; if (pl !== 1)   begin n_fail++; $display("FAIL main_done_pulses got %0d want 1", pl); end
    n_tests++; if (m_tt !== model_tt(r_rows)) begin n_fail++; $display("FAIL main_tt got %h want %h", m_tt, model_tt(r_rows)); end
    n_tests++; if (m_match !== 1'b1) begin n_fail++; $display("FAIL main_match got %b want 1", m_match); end
  endtask

  task automatic test_flipped_minterm;
    int dk, de, pl, lb;
    r_sel = 1'b0; set_func(16'hD4E4); r_rows[10] = 1'b0;
    run_sweep(-1, -1, -1, dk, de, pl, lb);
    n_tests++; if (m_tt !== 16'hD4C4) begin n_fail++; $display("FAIL flip_tt got %h want D4C4", m_tt); end
    n_tests++; if (m_match !== 1'b0)  begin n_fail++; $display("FAIL flip_match got %b want 0", m_match); end
  endtask

  task automatic test_reset_mid_sweep;
    int dk, de, pl, lb;
    r_sel = 1'b0; set_func(16'hD4E4);
    @(negedge clk); set_start(1'b1);
    @(posedge clk);
    @(negedge clk); set_start(1'b0);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.match !== 1'b0)
      begin n_fail++; $display("FAIL midrst_flags got busy=%b done=%b match=%b want 0 0 0", b0.busy, b0.done, b0.match); end
    n_tests++; if (b0.drv_in !== 4'd0) begin n_fail++; $display("FAIL midrst_drv got %h want 0", b0.drv_in); end
    n_tests++; if (b0.tt !== 16'h0)   begin n_fail++; $display("FAIL midrst_tt got %h want 0", b0.tt); end
    @(negedge clk); rst_n = 1'b1;
    run_sweep(-1, -1, -1, dk, de, pl, lb);
    n_tests++; if (dk !== 32) begin n_fail++; $display("FAIL midrst_resweep_latency got %0d want 32", dk); end
    n_tests++; if (m_tt !== 16'hD4E4 || m_match !== 1'b1)
      begin n_fail++; $display("FAIL midrst_resweep_tt got %h/%b want D4E4/1", m_tt, m_match); end
  endtask

  task automatic test_start_ignored;
    int dk, de, pl, lb;
    r_sel = 1'b0; set_func(16'hD4E4);
    run_sweep(5, 31, -1, dk, de, pl, lb);
    n_tests++; if (dk !== 32) begin n_fail++; $display("FAIL ign_latency got %0d want 32", dk); end
    n_tests++; if (de !== 0)  begin n_fail++; $display("FAIL ign_drv_steps got %0d bad cycles want 0", de); end
    n_tests++; if (pl !== 1)  begin n_fail++; $display("FAIL ign_done_pulses got %0d want 1", pl); end
    n_tests++; if (lb !== 0)  begin n_fail++; $display("FAIL ign_restart got %0d busy cycles after done want 0", lb); end
    n_tests++; if (m_tt !== 16'hD4E4) begin n_fail++; $display("FAIL ign_tt got %h want D4E4", m_tt); end
  endtask

  task automatic test_settle1;
    int dk, de, pl, lb;
    r_sel = 1'b1; set_func(16'hD4E4);
    run_sweep(-1, -1, -1, dk, de, pl, lb);
    n_tests++; if (dk !== 16) begin n_fail++; $display("FAIL s1_latency got %0d want 16", dk); end
    n_tests++; if (de !== 0)  begin n_fail++; $display("FAIL s1_drv_steps got %0d bad cycles want 0", de); end
    n_tests++; if (m_tt !== 16'hD4E4 || m_match !== 1'b1)
      begin n_fail++; $display("FAIL s1_tt got %h/%b want D4E4/1", m_tt, m_match); end
    r_sel = 1'b0;
  endtask

  task automatic test_random;
    int dk, de, pl, lb;
    logic [15:0] exp_tt;
    for (int it = 0; it < 6; it++) begin
      r_sel = it[0];
      for (int i = 0; i < 16; i++) r_rows[i] = 1'($urandom_range(0, 1));
      if (it == 2) set_func(16'hD4E4);
      exp_tt = model_tt(r_rows);
      run_sweep(-1, -1, -1, dk, de, pl, lb);
      n_tests++; if (dk !== (r_sel ? 16 : 32)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d", it, dk); end
      n_tests++; if (m_tt !== exp_tt) begin n_fail++; $display("FAIL rnd%0d_tt got %h want %h", it, m_tt, exp_tt); end
      n_tests++; if (m_match !== (exp_tt == 16'hD4E4)) begin n_fail++; $display("FAIL rnd%0d_match got %b want %b", it, m_match, exp_tt == 16'hD4E4); end
    end
    r_sel = 1'b0;
  endtask

`ifdef CELLO_TT_STABLE_CHECK_EN
  task automatic test_stable_check;
    int dk, de, pl, lb;
    r_sel = 1'b0; set_func(16'hD4E4);
    // k=6 is the first cycle of row 3: the row's reference value is corrupted.
    run_sweep(-1, -1, 6, dk, de, pl, lb);
    n_tests++; if (b0.unstable !== 1'b1) begin n_fail++; $display("FAIL stab_unstable got %b want 1", b0.unstable); end
    n_tests++; if (b0.match !== 1'b0)    begin n_fail++; $display("FAIL stab_match got %b want 0", b0.match); end
    n_tests++; if (b0.tt !== 16'hD4E4)   begin n_fail++; $display("FAIL stab_tt got %h want D4E4", b0.tt); end
    run_sweep(-1, -1, -1, dk, de, pl, lb);
    n_tests++; if (b0.unstable !== 1'b0 || b0.match !== 1'b1)
      begin n_fail++; $display("FAIL stab_clean got unstable=%b match=%b want 0 1", b0.unstable, b0.match); end
  endtask
`endif

  initial begin
    set_func(16'hD4E4);
    test_reset;
    test_main;
    test_flipped_minterm;
    test_reset_mid_sweep;
    test_start_ignored;
    test_settle1;
    test_random;
`ifdef CELLO_TT_STABLE_CHECK_EN
    test_stable_check;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
